// File: rtl/id_decode_stage_if.sv
// id_decode_stage_if
//   Bus between the IF/ID instruction register, the decode stage and ID/EX.
//   Signal names are from the stage's point of view (i_* into the stage, o_* out).
//   slave  : the decode stage itself
//   master : the surrounding pipeline (upstream source + downstream sink)
//   Upstream   : i_flush, i_vld, o_rdy, i_instr, i_pc
//   Downstream : o_vld, i_rdy, o_pc, o_instr, decoded controls, o_illegal_cnt
interface id_decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
);
    logic             i_flush;
    logic             i_vld;
    logic             o_rdy;
    logic [31:0]      i_instr;
    logic [XLEN-1:0]  i_pc;
    logic             o_vld;
    logic             i_rdy;
    logic [XLEN-1:0]  o_pc;
    logic [31:0]      o_instr;
    logic             o_insn_vld;
    logic             o_rd_wren;
    logic             o_mem_wren;
    logic             o_mem_ren;
    logic [1:0]       o_wb_sel;
    logic             o_opa_sel;
    logic             o_opb_sel;
    logic [4:0]       o_alu_op;
    logic             o_br_un;
    logic             o_is_branch;
    logic             o_is_jal;
    logic             o_is_jalr;
    logic             o_is_sys;
    logic [CNT_W-1:0] o_illegal_cnt;

    modport slave (
        input  i_flush, i_vld, i_instr, i_pc, i_rdy,
        output o_rdy, o_vld, o_pc, o_instr, o_insn_vld, o_rd_wren, o_mem_wren,
               o_mem_ren, o_wb_sel, o_opa_sel, o_opb_sel, o_alu_op, o_br_un,
               o_is_branch, o_is_jal, o_is_jalr, o_is_sys, o_illegal_cnt
    );

    modport master (
        output i_flush, i_vld, i_instr, i_pc, i_rdy,
        input  o_rdy, o_vld, o_pc, o_instr, o_insn_vld, o_rd_wren, o_mem_wren,
               o_mem_ren, o_wb_sel, o_opa_sel, o_opb_sel, o_alu_op, o_br_un,
               o_is_branch, o_is_jal, o_is_jalr, o_is_sys, o_illegal_cnt
    );
endinterface

// File: rtl/id_decode_stage.sv
// id_decode_stage
//   Registered RV32I(+M, +SYSTEM) decode stage with valid/ready handshake,
//   a one-entry skid buffer, flush, and a saturating illegal-instruction counter.
//   Ports:
//     i_clk    clock
//     i_reset  synchronous reset, active-high (dominates flush)
//     bus      id_decode_stage_if.slave: upstream instr/pc/valid/ready/flush,
//              downstream slot (pc, raw instr, decoded controls), illegal count
module id_decode_stage #(
    parameter int XLEN   = 32,
    parameter int EN_M   = 1,
    parameter int EN_SYS = 1,
    parameter int CNT_W  = 8
) (
    input logic               i_clk,
    input logic               i_reset,
    id_decode_stage_if.slave  bus
);

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_LUI   = 5'd10;
    localparam logic [4:0] ALU_AUIPC = 5'd11;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic       insn_vld;
        logic       rd_wren;
        logic       mem_wren;
        logic       mem_ren;
        logic [1:0] wb_sel;
        logic       opa_sel;
        logic       opb_sel;
        logic [4:0] alu_op;
        logic       br_un;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       is_sys;
    } ctrl_t;

    // Value of an illegal slot and of the reset state.
    localparam ctrl_t CTRL_NOP = '{insn_vld: 1'b0, rd_wren: 1'b0, mem_wren: 1'b0,
                                   mem_ren: 1'b0, wb_sel: 2'b00, opa_sel: 1'b0,
                                   opb_sel: 1'b0, alu_op: ALU_ADD, br_un: 1'b1,
                                   is_branch: 1'b0, is_jal: 1'b0, is_jalr: 1'b0,
                                   is_sys: 1'b0};

    function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t      c;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = instr[6:0];
        f3  = instr[14:12];
        f7  = instr[31:25];
        c   = CTRL_NOP;
        case (opc)
            OPC_OP: begin
                if (f7 == 7'b0000000) begin
                    c.insn_vld = 1'b1;
                    c.alu_op   = alu_base(f3, 1'b0);
                end else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    c.insn_vld = 1'b1;
                    c.alu_op   = alu_base(f3, 1'b1);
                end else if (f7 == 7'b0000001 && EN_M != 0) begin
                    c.insn_vld = 1'b1;
                    c.alu_op   = {2'b10, f3};
                end
                c.rd_wren = c.insn_vld;
            end
            OPC_OP_IMM: begin
                // Shift-immediates carry funct7 in the immediate field.
                if (f3 == 3'd1)
                    c.insn_vld = (f7 == 7'b0000000);
                else if (f3 == 3'd5)
                    c.insn_vld = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else
                    c.insn_vld = 1'b1;
                if (c.insn_vld) begin
                    c.rd_wren = 1'b1;
                    c.opb_sel = 1'b1;
                    c.alu_op  = alu_base(f3, (f3 == 3'd5) && instr[30]);
                end
            end
            OPC_LOAD: begin
                if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) begin
                    c.insn_vld = 1'b1;
                    c.rd_wren  = 1'b1;
                    c.mem_ren  = 1'b1;
                    c.wb_sel   = 2'b01;
                    c.opb_sel  = 1'b1;
                end
            end
            OPC_STORE: begin
                if (f3 <= 3'd2) begin
                    c.insn_vld = 1'b1;
                    c.mem_wren = 1'b1;
                    c.opb_sel  = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (f3 != 3'd2 && f3 != 3'd3) begin
                    c.insn_vld  = 1'b1;
                    c.is_branch = 1'b1;
                    c.opa_sel   = 1'b1;
                    c.opb_sel   = 1'b1;
                    c.br_un     = ~(f3 == 3'd6 || f3 == 3'd7);
                end
            end
            OPC_LUI: begin
                c.insn_vld = 1'b1;
                c.rd_wren  = 1'b1;
                c.opb_sel  = 1'b1;
                c.alu_op   = ALU_LUI;
            end
            OPC_AUIPC: begin
                c.insn_vld = 1'b1;
                c.rd_wren  = 1'b1;
                c.opa_sel  = 1'b1;
                c.opb_sel  = 1'b1;
                c.alu_op   = ALU_AUIPC;
            end
            OPC_JAL: begin
                c.insn_vld = 1'b1;
                c.rd_wren  = 1'b1;
                c.wb_sel   = 2'b10;
                c.opa_sel  = 1'b1;
                c.opb_sel  = 1'b1;
                c.is_jal   = 1'b1;
            end
            OPC_JALR: begin
                if (f3 == 3'd0) begin
                    c.insn_vld = 1'b1;
                    c.rd_wren  = 1'b1;
                    c.wb_sel   = 2'b10;
                    c.opb_sel  = 1'b1;
                    c.is_jalr  = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                if (EN_SYS != 0 && (instr == 32'h0000_0073 || instr == 32'h0010_0073)) begin
                    c.insn_vld = 1'b1;
                    c.is_sys   = 1'b1;
                end
            end
            OPC_FENCE: begin
                if (EN_SYS != 0 && f3 == 3'd0) begin
                    c.insn_vld = 1'b1;
                    c.is_sys   = 1'b1;
                end
            end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

    ctrl_t            in_ctrl;
    ctrl_t            main_ctrl;
    ctrl_t            skid_ctrl;
    logic             main_vld;
    logic             skid_vld;
    logic [XLEN-1:0]  main_pc;
    logic [XLEN-1:0]  skid_pc;
    logic [31:0]      main_instr;
    logic [31:0]      skid_instr;
    logic [CNT_W-1:0] illegal_cnt;
    logic             accept;
    logic             main_free;

    assign in_ctrl   = decode(bus.i_instr);
    // o_rdy is the registered ~skid_vld, so accept never overruns the skid.
    assign accept    = bus.i_vld & ~skid_vld & ~bus.i_flush;
    // Main can take a new entry when empty or when it hands its slot off now.
    assign main_free = ~main_vld | bus.i_rdy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            main_vld    <= 1'b0;
            main_ctrl   <= CTRL_NOP;
            main_pc     <= '0;
            main_instr  <= '0;
            skid_vld    <= 1'b0;
            skid_ctrl   <= CTRL_NOP;
            skid_pc     <= '0;
            skid_instr  <= '0;
            illegal_cnt <= '0;
        end else if (bus.i_flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            if (main_free) begin
                if (skid_vld) begin
                    // Older skid entry goes first; any new accept refills the skid.
                    main_vld   <= 1'b1;
                    main_ctrl  <= skid_ctrl;
                    main_pc    <= skid_pc;
                    main_instr <= skid_instr;
                    skid_vld   <= accept;
                    if (accept) begin
                        skid_ctrl  <= in_ctrl;
                        skid_pc    <= bus.i_pc;
                        skid_instr <= bus.i_instr;
                    end
                end else begin
                    main_vld <= accept;
                    if (accept) begin
                        main_ctrl  <= in_ctrl;
                        main_pc    <= bus.i_pc;
                        main_instr <= bus.i_instr;
                    end
                end
            end else if (accept) begin
                skid_vld   <= 1'b1;
                skid_ctrl  <= in_ctrl;
                skid_pc    <= bus.i_pc;
                skid_instr <= bus.i_instr;
            end
            if (accept && !in_ctrl.insn_vld && illegal_cnt != {CNT_W{1'b1}})
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    assign bus.o_rdy         = ~skid_vld;
    assign bus.o_vld         = main_vld;
    assign bus.o_pc          = main_pc;
    assign bus.o_instr       = main_instr;
    assign bus.o_insn_vld    = main_ctrl.insn_vld;
    assign bus.o_rd_wren     = main_ctrl.rd_wren;
    assign bus.o_mem_wren    = main_ctrl.mem_wren;
    assign bus.o_mem_ren     = main_ctrl.mem_ren;
    assign bus.o_wb_sel      = main_ctrl.wb_sel;
    assign bus.o_opa_sel     = main_ctrl.opa_sel;
    assign bus.o_opb_sel     = main_ctrl.opb_sel;
    assign bus.o_alu_op      = main_ctrl.alu_op;
    assign bus.o_br_un       = main_ctrl.br_un;
    assign bus.o_is_branch   = main_ctrl.is_branch;
    assign bus.o_is_jal      = main_ctrl.is_jal;
    assign bus.o_is_jalr     = main_ctrl.is_jalr;
    assign bus.o_is_sys      = main_ctrl.is_sys;
    assign bus.o_illegal_cnt = illegal_cnt;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage
//   Directed bench for id_decode_stage. dut uses EN_M=1/EN_SYS=1; dut_nm uses
//   EN_M=0/EN_SYS=0 and sees the same input stream.
module tb_id_decode_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    id_decode_stage_if #(.XLEN(32), .CNT_W(8)) bus ();
    id_decode_stage_if #(.XLEN(32), .CNT_W(8)) bus_nm ();

    assign bus_nm.i_flush = bus.i_flush;
    assign bus_nm.i_vld   = bus.i_vld;
    assign bus_nm.i_instr = bus.i_instr;
    assign bus_nm.i_pc    = bus.i_pc;
    assign bus_nm.i_rdy   = bus.i_rdy;

    id_decode_stage #(.XLEN(32), .EN_M(1), .EN_SYS(1), .CNT_W(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    id_decode_stage #(.XLEN(32), .EN_M(0), .EN_SYS(0), .CNT_W(8)) dut_nm (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_nm)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] pc);
        bus.i_vld   = vld;
        bus.i_instr = instr;
        bus.i_pc    = pc;
    endtask

    initial begin
        bus.i_flush = 1'b0;
        bus.i_rdy   = 1'b1;
        drive(1'b0, 32'h0, 32'h0);

        // reset
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_vld",     32'(bus.o_vld), 32'd0);
        chk("rst_rdy",     32'(bus.o_rdy), 32'd1);
        chk("rst_cnt",     32'(bus.o_illegal_cnt), 32'd0);
        chk("rst_pc",      bus.o_pc, 32'd0);
        chk("rst_instr",   bus.o_instr, 32'd0);
        chk("rst_insn",    32'(bus.o_insn_vld), 32'd0);
        chk("rst_alu",     32'(bus.o_alu_op), 32'd0);
        chk("rst_br_un",   32'(bus.o_br_un), 32'd1);

        // add x1,x2,x3
        drive(1'b1, 32'h003100B3, 32'h100);
        tick();
        chk("add_vld",   32'(bus.o_vld), 32'd1);
        chk("add_insn",  32'(bus.o_insn_vld), 32'd1);
        chk("add_wren",  32'(bus.o_rd_wren), 32'd1);
        chk("add_alu",   32'(bus.o_alu_op), 32'd0);
        chk("add_opb",   32'(bus.o_opb_sel), 32'd0);
        chk("add_pc",    bus.o_pc, 32'h100);
        chk("add_instr", bus.o_instr, 32'h003100B3);

        // mul
        drive(1'b1, 32'h023100B3, 32'h104);
        tick();
        chk("mul_alu",     32'(bus.o_alu_op), 32'd16);
        chk("mul_insn",    32'(bus.o_insn_vld), 32'd1);
        chk("mul_cnt",     32'(bus.o_illegal_cnt), 32'd0);
        chk("mul_pc",      bus.o_pc, 32'h104);
        chk("nm_mul_vld",  32'(bus_nm.o_vld), 32'd1);
        chk("nm_mul_insn", 32'(bus_nm.o_insn_vld), 32'd0);
        chk("nm_mul_wren", 32'(bus_nm.o_rd_wren), 32'd0);
        chk("nm_mul_cnt",  32'(bus_nm.o_illegal_cnt), 32'd1);
        chk("nm_mul_alu",  32'(bus_nm.o_alu_op), 32'd0);

        // bltu
        drive(1'b1, 32'h0020E463, 32'h108);
        tick();
        chk("bltu_br",    32'(bus.o_is_branch), 32'd1);
        chk("bltu_br_un", 32'(bus.o_br_un), 32'd0);
        chk("bltu_opa",   32'(bus.o_opa_sel), 32'd1);
        chk("bltu_opb",   32'(bus.o_opb_sel), 32'd1);
        chk("bltu_wren",  32'(bus.o_rd_wren), 32'd0);

        // ecall
        drive(1'b1, 32'h00000073, 32'h10C);
        tick();
        chk("ecall_sys",   32'(bus.o_is_sys), 32'd1);
        chk("ecall_insn",  32'(bus.o_insn_vld), 32'd1);
        chk("ecall_wren",  32'(bus.o_rd_wren), 32'd0);
        chk("ecall_mwr",   32'(bus.o_mem_wren), 32'd0);
        chk("nm_ecall_in", 32'(bus_nm.o_insn_vld), 32'd0);
        chk("nm_ecall_sy", 32'(bus_nm.o_is_sys), 32'd0);
        chk("nm_ecall_ct", 32'(bus_nm.o_illegal_cnt), 32'd2);

        // lw x1,0(x1)
        drive(1'b1, 32'h0000A083, 32'h110);
        tick();
        chk("lw_ren",  32'(bus.o_mem_ren), 32'd1);
        chk("lw_wb",   32'(bus.o_wb_sel), 32'd1);
        chk("lw_wren", 32'(bus.o_rd_wren), 32'd1);

        // jal x0
        drive(1'b1, 32'h0000006F, 32'h114);
        tick();
        chk("jal_is",  32'(bus.o_is_jal), 32'd1);
        chk("jal_wb",  32'(bus.o_wb_sel), 32'd2);
        chk("jal_opa", 32'(bus.o_opa_sel), 32'd1);

        // srai x1,x1,1 (legal)
        drive(1'b1, 32'h4010D093, 32'h118);
        tick();
        chk("srai_insn", 32'(bus.o_insn_vld), 32'd1);
        chk("srai_alu",  32'(bus.o_alu_op), 32'd7);
        chk("srai_opb",  32'(bus.o_opb_sel), 32'd1);

        // slli with funct7=0100000 (illegal)
        drive(1'b1, 32'h40109093, 32'h11C);
        tick();
        chk("bslli_insn", 32'(bus.o_insn_vld), 32'd0);
        chk("bslli_wren", 32'(bus.o_rd_wren), 32'd0);
        chk("bslli_opb",  32'(bus.o_opb_sel), 32'd0);
        chk("bslli_cnt",  32'(bus.o_illegal_cnt), 32'd1);

        // load with f3=3 (illegal)
        drive(1'b1, 32'h0000B083, 32'h120);
        tick();
        chk("bld_ren", 32'(bus.o_mem_ren), 32'd0);
        chk("bld_cnt", 32'(bus.o_illegal_cnt), 32'd2);

        // fence
        drive(1'b1, 32'h0000000F, 32'h124);
        tick();
        chk("fence_sys", 32'(bus.o_is_sys), 32'd1);
        chk("fence_cnt", 32'(bus.o_illegal_cnt), 32'd2);

        // 300 illegal words: count 2 -> saturates at 255
        drive(1'b1, 32'hFFFFFFFF, 32'h200);
        repeat (252) tick();
        chk("sat_254", 32'(bus.o_illegal_cnt), 32'd254);
        tick();
        chk("sat_255", 32'(bus.o_illegal_cnt), 32'd255);
        repeat (47) tick();
        chk("sat_hold",  32'(bus.o_illegal_cnt), 32'd255);
        chk("sat_insn",  32'(bus.o_insn_vld), 32'd0);
        chk("sat_br_un", 32'(bus.o_br_un), 32'd1);
        chk("sat_vld",   32'(bus.o_vld), 32'd1);

        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("drain_vld", 32'(bus.o_vld), 32'd0);

        // stream A,B,C with i_rdy low for three cycles
        bus.i_rdy = 1'b0;
        drive(1'b1, 32'h00100093, 32'h300);
        tick();
        chk("stA_pc",  bus.o_pc, 32'h300);
        chk("stA_rdy", 32'(bus.o_rdy), 32'd1);
        drive(1'b1, 32'h00200093, 32'h304);
        tick();
        chk("stB_pc",  bus.o_pc, 32'h300);
        chk("stB_rdy", 32'(bus.o_rdy), 32'd0);
        drive(1'b1, 32'h00300093, 32'h308);
        tick();
        chk("stC_pc",  bus.o_pc, 32'h300);
        chk("stC_rdy", 32'(bus.o_rdy), 32'd0);
        bus.i_rdy = 1'b1;
        tick();
        chk("rel_pcB", bus.o_pc, 32'h304);
        chk("rel_rdy", 32'(bus.o_rdy), 32'd1);
        chk("rel_vld", 32'(bus.o_vld), 32'd1);
        tick();
        chk("rel_pcC",  bus.o_pc, 32'h308);
        chk("rel_insC", bus.o_instr, 32'h00300093);
        chk("rel_vldC", 32'(bus.o_vld), 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("rel_end", 32'(bus.o_vld), 32'd0);

        // reset while main+skid are full, together with flush
        bus.i_rdy = 1'b0;
        drive(1'b1, 32'h00100093, 32'h400);
        tick();
        drive(1'b1, 32'h00100093, 32'h404);
        tick();
        chk("rs_full_rdy", 32'(bus.o_rdy), 32'd0);
        rst = 1'b1;
        bus.i_flush = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("rs_vld", 32'(bus.o_vld), 32'd0);
        chk("rs_rdy", 32'(bus.o_rdy), 32'd1);
        chk("rs_cnt", 32'(bus.o_illegal_cnt), 32'd0);
        chk("rs_pc",  bus.o_pc, 32'd0);

        // flush with main+skid full
        drive(1'b1, 32'h003100B3, 32'h500);
        tick();
        drive(1'b1, 32'h003100B3, 32'h504);
        tick();
        chk("fl_full_rdy", 32'(bus.o_rdy), 32'd0);
        chk("fl_full_vld", 32'(bus.o_vld), 32'd1);
        bus.i_flush = 1'b1;
        drive(1'b1, 32'hFFFFFFFF, 32'h508);
        tick();
        chk("fl_vld", 32'(bus.o_vld), 32'd0);
        chk("fl_rdy", 32'(bus.o_rdy), 32'd1);
        chk("fl_cnt", 32'(bus.o_illegal_cnt), 32'd0);
        bus.i_flush = 1'b0;
        bus.i_rdy   = 1'b1;
        drive(1'b1, 32'h003100B3, 32'h50C);
        tick();
        chk("fl_next_vld", 32'(bus.o_vld), 32'd1);
        chk("fl_next_pc",  bus.o_pc, 32'h50C);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("fl_next_end", 32'(bus.o_vld), 32'd0);

        // flush drops a same-cycle illegal input while ready
        bus.i_flush = 1'b1;
        drive(1'b1, 32'hFFFFFFFF, 32'h600);
        tick();
        chk("fd_vld", 32'(bus.o_vld), 32'd0);
        chk("fd_cnt", 32'(bus.o_illegal_cnt), 32'd0);
        bus.i_flush = 1'b0;
        tick();
        chk("il_vld",  32'(bus.o_vld), 32'd1);
        chk("il_insn", 32'(bus.o_insn_vld), 32'd0);
        chk("il_cnt",  32'(bus.o_illegal_cnt), 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
